serial_subtractor: RTL and testbench

//  Multi-cycle wide subtractor: computes DIFF = A - B over WIDTH bits, CHUNK bits per cycle, LSB chunk first.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/chunk_subtractor.sv | 28 ++
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the chunk-serial subtractor.
// Used by serial_subtractor and its testbench.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ssub_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit x + ~y + cin, built as a ripple of
// full-adder cells with the y operand inverted.
module chunk_subtractor #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] d,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic yn;
        logic p;
        assign yn     = ~y[i];
        assign p      = x[i] ^ yn;
        assign d[i]   = p ^ c[i];
        assign c[i+1] = (x[i] & yn) | (c[i] & p);
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, CHUNK bits per cycle, LSB first.
// Optional signed overflow output: define SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int CHUNK = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             borrow,
    output logic             overflow
`else
    output logic             borrow
`endif
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CW         = cnt_w(NUM_CHUNKS);
    localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

    if ((WIDTH % CHUNK) != 0 || NUM_CHUNKS < 1) begin : g_bad_cfg
        $error("serial_subtractor: WIDTH must be a nonzero multiple of CHUNK");
    end

    ssub_state_e      state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK-1:0] d_chunk;
    logic             c_out;

    chunk_subtractor #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x    (a_sh[CHUNK-1:0]),
        .y    (b_sh[CHUNK-1:0]),
        .cin  (carry),
        .d    (d_chunk),
        .cout (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b1;
            a_sh      <= '0;
            b_sh      <= '0;
            diff      <= '0;
            borrow    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff[int'(cnt)*CHUNK +: CHUNK] <= d_chunk;
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    if (cnt == LAST) begin
                        // No carry out of the top chunk means a < b.
                        borrow    <= ~c_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow  <= (a_sh[CHUNK-1] != b_sh[CHUNK-1]) &&
                                     (d_chunk[CHUNK-1] != a_sh[CHUNK-1]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor (256/64),
// scoreboarded against a plain-arithmetic reference.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W   = 256;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(
        .WIDTH (W),
        .CHUNK (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .borrow    (borrow),
        .overflow  (overflow)
`else
        .borrow    (borrow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        return x - y;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x,
                                     input logic [W-1:0] y);
        logic signed [W:0] sd;
        sd = $signed({x[W-1], x}) - $signed({y[W-1], y});
        return sd[W] != sd[W-1];
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Full transaction: accept, latency, backpressure hold, handshake.
    task automatic do_op(input string tag, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int hold);
        int cyc;
        logic [W-1:0] d_exp;
        logic bo_exp;
        d_exp  = ref_diff(x, y);
        bo_exp = (x < y);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, ":in_ready_idle"}, W'(in_ready), W'(1));
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        a = rnd();
        b = rnd();
        chk({tag, ":in_ready_busy"}, W'(in_ready), W'(0));
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            // Busy requests must be ignored.
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            cyc++;
        end
        chk({tag, ":latency"}, W'(cyc), W'(NCH));
        chk({tag, ":diff"}, diff, d_exp);
        chk({tag, ":borrow"}, W'(borrow), W'(bo_exp));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({tag, ":overflow"}, W'(overflow), W'(ref_ovf(x, y)));
`endif
        if (hold > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk({tag, ":hold_valid"}, W'(out_valid), W'(1));
                chk({tag, ":hold_diff"}, diff, d_exp);
                chk({tag, ":hold_borrow"}, W'(borrow), W'(bo_exp));
                chk({tag, ":hold_in_ready"}, W'(in_ready), W'(0));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        chk({tag, ":post_valid"}, W'(out_valid), W'(0));
        chk({tag, ":post_in_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] dead;
        logic [W-1:0] hold_a;
        one = W'(1);
        dead = {8{32'hDEADBEEF}};
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk("rst:in_ready", W'(in_ready), W'(1));
        chk("rst:out_valid", W'(out_valid), W'(0));
        chk("rst:diff", diff, '0);
        chk("rst:borrow", W'(borrow), W'(0));
        rst_n = 1'b1;
        tick();

        do_op("t1_5m3", W'(5), W'(3), 0);
        do_op("t2_0m1", '0, one, 0);
        chk("t2:all_ones", diff, {W{1'b1}});
        do_op("t2_eq", dead, dead, 0);
        do_op("t3_2p64", one << 64, one, 0);
        do_op("t3_2p192", one << 192, one, 0);
        do_op("t4_bp", W'(100), W'(200), 10);

        // A request held through the handshake is taken the cycle after.
        hold_a = rnd();
        a = hold_a;
        b = W'(9);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4b:accept_in_ready", W'(in_ready), W'(0));
        for (int i = 0; i < NCH; i++) tick();
        chk("t4b:valid", W'(out_valid), W'(1));
        chk("t4b:diff", diff, ref_diff(hold_a, W'(9)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Abort mid-RUN with counter at 2.
        a = W'(77);
        b = W'(3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5:in_ready", W'(in_ready), W'(1));
        chk("t5:out_valid", W'(out_valid), W'(0));
        chk("t5:diff", diff, '0);
        chk("t5:borrow", W'(borrow), W'(0));
        chk("t5:state", W'(dut.state), W'(IDLE));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NCH + 2; i++) begin
            tick();
            chk("t5:no_result", W'(out_valid), W'(0));
        end
        do_op("t5_7m2", W'(7), W'(2), 0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        do_op("t6_min", one << 255, one, 0);
        chk("t6:ovf1", W'(overflow), W'(1));
        do_op("t6_1m2", one, W'(2), 0);
        chk("t6:ovf0", W'(overflow), W'(0));
`endif

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = rnd();
            y = ($urandom_range(0, 5) == 0) ? x : rnd();
            do_op($sformatf("rnd%0d", n), x, y, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
